driver_prog_seq: RTL and testbench
==================================

# driver_prog_seq

Program sequencer for the pattern driver. It takes the run/end/abort/freeze controls and FIFO thresholds from the driver control register block, and the fill levels from the address and vector FIFOs. It pops base addresses from the address FIFO, optionally expands each into a run of consecutive addresses, and issues them to the vector fetch engine over a valid/ready handshake. It also reports sequencer state and counts back to the register block for status readback.

## Interface
- ADDR_W, 32, width of address FIFO words and issued addresses
- LVL_W, 16, width of FIFO level and threshold inputs
- CNT_W, 16, width of issued-address counter

Ports:
- clk  in  1  single clock; all logic is synchronous to it
- reset  in  1  asynchronous, active-high; all state is cleared while high
- run_program  in  1  start request; the sequencer acts on the rising edge only
- end_program  in  1  level: no more address words will be written
- abort_program  in  1  level: abort the current program
- freeze_addr_fifo  in  1  blocks address FIFO pops
- freeze_vector_fifo  in  1  blocks address issue
- send_consec_addr  in  1  enables consecutive expansion
- consec_count  in  8  number of extra consecutive addresses per base word
- addr_fifo_threshold  in  LVL_W  prime level
- vector_fifo_threshold  in  LVL_W  backpressure level
- words_in_addr_fifo  in  LVL_W  address FIFO fill level
- words_in_vctr_fifo  in  LVL_W  vector FIFO fill level
- addr_fifo_empty  in  1  address FIFO empty flag
- vector_fifo_full  in  1  vector FIFO full flag
- addr_fifo_dout  in  ADDR_W  first-word-fall-through head; valid when !addr_fifo_empty
- addr_fifo_rd  out  1  pop strobe
- vec_addr  out  ADDR_W  issued address
- vec_addr_valid  out  1  issued address is valid
- vec_addr_ready  in  1  fetch engine accepts the address
- seq_state  out  3  current state encoding
- seq_busy  out  1  high in any state except IDLE
- seq_done  out  1  1-cycle pulse on normal completion
- seq_aborted  out  1  1-cycle pulse on abort
- addr_starved  out  1  sticky per program: RUN saw an empty FIFO without end_program
- issued_cnt  out  CNT_W  addresses accepted since start; saturates at all-ones

## Operation
- State encodings: IDLE=0, PRIME=1, RUN=2, DRAIN=3, DONE=4.
- IDLE → PRIME on a rising edge of run_program.
  - On entry to PRIME, clear issued_cnt and addr_starved.
- PRIME → RUN when words_in_addr_fifo >= addr_fifo_threshold, or when end_program=1.
- RUN:
  - Define slot_free = !vec_addr_valid || vec_addr_ready.
  - Define issue_ok = !freeze_vector_fifo && !vector_fifo_full && words_in_vctr_fifo < vector_fifo_threshold.
  - If slot_free && issue_ok:
    - With a burst remaining, issue base+offset and increment offset.
    - Otherwise, if !freeze_addr_fifo && !addr_fifo_empty, pop the FIFO (addr_fifo_rd=1) and issue addr_fifo_dout as the new base.
  - When a new base is popped, sample burst length = send_consec_addr ? consec_count+1 : 1.
  - Address addition wraps modulo 2^ADDR_W.
- RUN → DRAIN when end_program && addr_fifo_empty && no burst remaining.
- addr_fifo_empty in RUN with end_program=0: stay in RUN and set addr_starved.
- DRAIN → DONE when vec_addr_valid=0, or when the final handshake completes.
- DONE → IDLE unconditionally; seq_done pulses during DONE.
- abort_program in any non-IDLE state → IDLE on the next edge:
  - vec_addr_valid drops and the burst state clears;
  - seq_aborted pulses for 1 cycle;
  - no pop occurs that cycle.
  - abort wins over every other transition.
- issued_cnt increments on each vec_addr_valid && vec_addr_ready.

## Timing
- Reset values:
  - all outputs 0;
  - state IDLE;
  - run_program edge register 0, so a run held high through reset does not start a program.
- run edge seen at edge N: PRIME at N+1.
- Prime condition true in PRIME: RUN at the next edge.
- First pop occurs in the first RUN cycle; vec_addr_valid rises on the following edge.
- Sustained throughput is 1 address per cycle with ready held high.
- Handshake: once valid is asserted, vec_addr is stable and valid stays high until ready, except on abort.
- addr_fifo_rd is combinational from registered state and the FIFO flags; it is never asserted while empty.
- A rising edge of run_program while busy is ignored.
- Threshold changes take effect on the next cycle.

## Configuration
- DRIVER_SEQ_CONSEC_EN defined: consecutive expansion is implemented as described.
- DRIVER_SEQ_CONSEC_EN undefined:
  - burst length is fixed at 1;
  - send_consec_addr and consec_count are ignored;
  - the offset counter and adder are not built.

## Structure
- Shared package driver_seq_pkg holds:
  - the state enum and its encodings;
  - ADDR_W, LVL_W and CNT_W defaults;
  - the consec_count width constant (8).
- Sub-module driver_seq_burst: base/offset/remaining registers and adder.
  - Inputs: load, advance, base, len.
  - Outputs: addr, last.
  - Excluded entirely without DRIVER_SEQ_CONSEC_EN.

## Test plan
- Basic run:
  - stimulus: threshold=4, 4 words (0x100..0x103) preloaded, ready=1, run edge, then end_program=1;
  - response: addresses 0x100..0x103 on consecutive cycles, then DRAIN and DONE, seq_done 1 cycle, issued_cnt=4.
- Consecutive expansion:
  - stimulus: send_consec_addr=1, consec_count=2, words 0x10 and 0xFFFFFFFF;
  - response: addresses 0x10, 0x11, 0x12, 0xFFFFFFFF, 0x0, 0x1 (wrap), issued_cnt=6.
- Backpressure:
  - stimulus: words_in_vctr_fifo=vector_fifo_threshold for 5 cycles mid-run, with ready toggling;
  - response: no new issue and no pop while blocked; vec_addr held stable while valid and not ready; no address lost or duplicated.
- Starvation:
  - stimulus: FIFO empties in RUN with end_program=0;
  - response: addr_starved=1 and state stays RUN; after 2 more words and end_program, normal DONE.
- Abort:
  - stimulus: abort_program during a 3-address burst with valid pending;
  - response: IDLE on the next edge, valid=0, seq_aborted pulse, no further pops.
  - Reset asserted mid-RUN: all outputs are 0 immediately (asynchronous).

Source files
------------

// File: rtl/driver_seq_pkg.sv
// Shared definitions for the pattern-driver program sequencer.
// Holds the sequencer state encodings, default bus widths and the
// width of the consecutive-address count field.
package driver_seq_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int LVL_W_DEF  = 16;
    localparam int CNT_W_DEF  = 16;
    localparam int CONSEC_W   = 8;

    // Encodings are visible to software through seq_state; keep them fixed.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRIME = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_t;

endpackage

// File: rtl/driver_seq_burst.sv
// Consecutive-address expander: holds the current base word, the running
// offset and the count of addresses still to issue for that base.
// Ports: clk/rst; clear drops any burst in progress; load captures a new
// base and burst length (the base itself is issued by the caller, so
// len-1 extra addresses remain); advance steps to the next offset.
// addr = base + offset (wraps modulo 2^ADDR_W); last = nothing remains.
module driver_seq_burst
    import driver_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic              advance,
    input  logic [ADDR_W-1:0] base,
    input  logic [CONSEC_W:0] len,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [ADDR_W-1:0]   base_q;
    logic [CONSEC_W-1:0] offset_q;
    logic [CONSEC_W:0]   remaining_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q      <= '0;
            offset_q    <= '0;
            remaining_q <= '0;
        end else if (clear) begin
            offset_q    <= '0;
            remaining_q <= '0;
        end else if (load) begin
            base_q      <= base;
            offset_q    <= CONSEC_W'(1);
            remaining_q <= len - 1'b1;
        end else if (advance && remaining_q != '0) begin
            offset_q    <= offset_q + 1'b1;
            remaining_q <= remaining_q - 1'b1;
        end
    end

    assign addr = base_q + ADDR_W'(offset_q);
    assign last = (remaining_q == '0);

endmodule

// File: rtl/driver_prog_seq.sv
// Program sequencer: pops base addresses from the address FIFO, optionally
// expands each into consecutive addresses, and issues them to the vector
// fetch engine over valid/ready. Reports state, counts and pulses for status.
// Ports: run/end/abort/freeze controls and thresholds from the register
// block; FIFO levels/flags/head; addr_fifo_rd pop; vec_addr valid/ready
// issue channel; seq_* status, addr_starved, issued_cnt.
// Optional feature macro: DRIVER_SEQ_CONSEC_EN enables consecutive expansion.
module driver_prog_seq
    import driver_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LVL_W  = LVL_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run_program,
    input  logic                end_program,
    input  logic                abort_program,
    input  logic                freeze_addr_fifo,
    input  logic                freeze_vector_fifo,
    input  logic                send_consec_addr,
    input  logic [CONSEC_W-1:0] consec_count,
    input  logic [LVL_W-1:0]    addr_fifo_threshold,
    input  logic [LVL_W-1:0]    vector_fifo_threshold,
    input  logic [LVL_W-1:0]    words_in_addr_fifo,
    input  logic [LVL_W-1:0]    words_in_vctr_fifo,
    input  logic                addr_fifo_empty,
    input  logic                vector_fifo_full,
    input  logic [ADDR_W-1:0]   addr_fifo_dout,
    output logic                addr_fifo_rd,
    output logic [ADDR_W-1:0]   vec_addr,
    output logic                vec_addr_valid,
    input  logic                vec_addr_ready,
    output logic [2:0]          seq_state,
    output logic                seq_busy,
    output logic                seq_done,
    output logic                seq_aborted,
    output logic                addr_starved,
    output logic [CNT_W-1:0]    issued_cnt
);

    seq_state_t        state_q, state_d;
    logic              run_q, run_armed, run_rise;
    logic [ADDR_W-1:0] vec_addr_q;
    logic              vld_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              starved_q, aborted_q;
    logic              abort_now, in_run, slot_free, issue_ok;
    logic              pop, burst_issue, burst_rem, start_prime;

    // run_armed only rises once run_program has been seen low, so a run
    // request held high across reset is not mistaken for a new edge.
    assign run_rise    = run_program && !run_q && run_armed;
    assign abort_now   = abort_program && (state_q != ST_IDLE);
    assign in_run      = (state_q == ST_RUN) && !abort_now;
    assign slot_free   = !vld_q || vec_addr_ready;
    assign issue_ok    = !freeze_vector_fifo && !vector_fifo_full &&
                         (words_in_vctr_fifo < vector_fifo_threshold);
    // Remaining burst addresses take priority over popping a new base.
    assign burst_issue = in_run && slot_free && issue_ok && burst_rem;
    assign pop         = in_run && slot_free && issue_ok && !burst_rem &&
                         !freeze_addr_fifo && !addr_fifo_empty;
    assign start_prime = (state_q == ST_IDLE) && (state_d == ST_PRIME);

`ifdef DRIVER_SEQ_CONSEC_EN
    logic [ADDR_W-1:0] burst_addr;
    logic              burst_last;
    logic [CONSEC_W:0] burst_len;

    assign burst_len = send_consec_addr ? ({1'b0, consec_count} + 1'b1)
                                        : (CONSEC_W+1)'(1);
    assign burst_rem = !burst_last;

    driver_seq_burst #(.ADDR_W(ADDR_W)) u_burst (
        .clk     (clk),
        .rst     (reset),
        .clear   (abort_now),
        .load    (pop),
        .advance (burst_issue),
        .base    (addr_fifo_dout),
        .len     (burst_len),
        .addr    (burst_addr),
        .last    (burst_last)
    );
`else
    logic unused_consec;
    assign unused_consec = ^{send_consec_addr, consec_count};
    assign burst_rem     = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (run_rise) state_d = ST_PRIME;
            ST_PRIME: if (words_in_addr_fifo >= addr_fifo_threshold || end_program)
                          state_d = ST_RUN;
            ST_RUN:   if (end_program && addr_fifo_empty && !burst_rem)
                          state_d = ST_DRAIN;
            ST_DRAIN: if (!vld_q || vec_addr_ready) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (abort_now) state_d = ST_IDLE;
    end

    // Output logic
    always_comb begin
        addr_fifo_rd = pop;
        seq_state    = state_q;
        seq_busy     = (state_q != ST_IDLE);
        seq_done     = (state_q == ST_DONE);
    end

    // Issue register, counters and status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_q      <= 1'b0;
            run_armed  <= 1'b0;
            vec_addr_q <= '0;
            vld_q      <= 1'b0;
            cnt_q      <= '0;
            starved_q  <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            run_q     <= run_program;
            run_armed <= run_armed || !run_program;
            aborted_q <= abort_now;

            if (abort_now) begin
                vld_q <= 1'b0;
            end else if (pop) begin
                vec_addr_q <= addr_fifo_dout;
                vld_q      <= 1'b1;
`ifdef DRIVER_SEQ_CONSEC_EN
            end else if (burst_issue) begin
                vec_addr_q <= burst_addr;
                vld_q      <= 1'b1;
`endif
            end else if (vec_addr_ready) begin
                vld_q <= 1'b0;
            end

            if (start_prime)
                cnt_q <= '0;
            else if (vld_q && vec_addr_ready && cnt_q != '1)
                cnt_q <= cnt_q + 1'b1;

            if (start_prime)
                starved_q <= 1'b0;
            else if (in_run && addr_fifo_empty && !end_program)
                starved_q <= 1'b1;
        end
    end

    assign vec_addr       = vec_addr_q;
    assign vec_addr_valid = vld_q;
    assign issued_cnt     = cnt_q;
    assign addr_starved   = starved_q;
    assign seq_aborted    = aborted_q;

endmodule

// File: tb/tb_driver_prog_seq.sv
// Directed bench for driver_prog_seq: a cycle table for a basic program,
// then hand-written sequences for expansion, backpressure, starvation,
// abort and asynchronous reset. A queue models the address FIFO.
module tb_driver_prog_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        run_program, end_program, abort_program;
    logic        freeze_addr_fifo, freeze_vector_fifo, send_consec_addr;
    logic [7:0]  consec_count;
    logic [15:0] addr_fifo_threshold, vector_fifo_threshold;
    logic [15:0] words_in_addr_fifo, words_in_vctr_fifo;
    logic        addr_fifo_empty, vector_fifo_full;
    logic [31:0] addr_fifo_dout;
    logic        addr_fifo_rd;
    logic [31:0] vec_addr;
    logic        vec_addr_valid, vec_addr_ready;
    logic [2:0]  seq_state;
    logic        seq_busy, seq_done, seq_aborted, addr_starved;
    logic [15:0] issued_cnt;

    driver_prog_seq dut (
        .clk(clk), .reset(reset),
        .run_program(run_program), .end_program(end_program),
        .abort_program(abort_program),
        .freeze_addr_fifo(freeze_addr_fifo), .freeze_vector_fifo(freeze_vector_fifo),
        .send_consec_addr(send_consec_addr), .consec_count(consec_count),
        .addr_fifo_threshold(addr_fifo_threshold),
        .vector_fifo_threshold(vector_fifo_threshold),
        .words_in_addr_fifo(words_in_addr_fifo), .words_in_vctr_fifo(words_in_vctr_fifo),
        .addr_fifo_empty(addr_fifo_empty), .vector_fifo_full(vector_fifo_full),
        .addr_fifo_dout(addr_fifo_dout), .addr_fifo_rd(addr_fifo_rd),
        .vec_addr(vec_addr), .vec_addr_valid(vec_addr_valid),
        .vec_addr_ready(vec_addr_ready),
        .seq_state(seq_state), .seq_busy(seq_busy), .seq_done(seq_done),
        .seq_aborted(seq_aborted), .addr_starved(addr_starved),
        .issued_cnt(issued_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int done_cnt = 0, bad_pop = 0, unstable = 0;
    logic [31:0] fq[$];
    logic [31:0] acc[$];
    logic [31:0] exp_q[$];

    typedef struct {
        logic        run, endp, rdy;
        logic [2:0]  st;
        logic        rd, vld;
        logic [31:0] addr;
        logic        done;
        logic [15:0] cnt;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic upd_fifo();
        words_in_addr_fifo = 16'(fq.size());
        addr_fifo_empty    = (fq.size() == 0);
        addr_fifo_dout     = (fq.size() == 0) ? 32'h0 : fq[0];
    endtask

    // One clock: sample the handshake/pop just before the edge, apply them after.
    task automatic tick();
        logic p, hs, stall;
        logic [31:0] a, tmp;
        #1;
        p     = addr_fifo_rd;
        hs    = vec_addr_valid && vec_addr_ready;
        a     = vec_addr;
        stall = vec_addr_valid && !vec_addr_ready && !abort_program && !reset;
        if (seq_done) done_cnt++;
        if (p && addr_fifo_empty) bad_pop++;
        @(posedge clk);
        #1;
        if (p && fq.size() > 0) tmp = fq.pop_front();
        if (hs) acc.push_back(a);
        if (stall && (!vec_addr_valid || vec_addr !== a)) unstable++;
        upd_fifo();
    endtask

    task automatic start_prog();
        run_program = 1'b1;
        tick();
        run_program = 1'b0;
    endtask

    task automatic run_to_idle(input int maxc);
        for (int i = 0; i < maxc; i++) begin
            if (seq_state == 3'd0) break;
            tick();
        end
        chk("prog_end_in_time", {29'd0, seq_state}, 32'd0);
    endtask

    task automatic chk_acc(input string nm);
        chk({nm, "_count"}, acc.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < acc.size(); i++)
            chk({nm, "_addr"}, acc[i], exp_q[i]);
    endtask

    task automatic flush();
        fq.delete(); acc.delete(); exp_q.delete();
        upd_fifo();
    endtask

    initial begin
        int d0, sz;
        reset = 1'b1;
        run_program = 1'b1;          // held high through reset
        end_program = 0; abort_program = 0;
        freeze_addr_fifo = 0; freeze_vector_fifo = 0; send_consec_addr = 0;
        consec_count = 0; addr_fifo_threshold = 16'd4; vector_fifo_threshold = 16'd16;
        words_in_vctr_fifo = 0; vector_fifo_full = 0; vec_addr_ready = 1'b1;
        flush();
        #12;
        chk("rst_state",   {29'd0, seq_state}, 0);
        chk("rst_busy",    {31'd0, seq_busy}, 0);
        chk("rst_valid",   {31'd0, vec_addr_valid}, 0);
        chk("rst_addr",    vec_addr, 0);
        chk("rst_rd",      {31'd0, addr_fifo_rd}, 0);
        chk("rst_cnt",     {16'd0, issued_cnt}, 0);
        chk("rst_flags",   {29'd0, seq_done, seq_aborted, addr_starved}, 0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (3) tick();
        chk("run_held_no_start", {29'd0, seq_state}, 0);
        run_program = 1'b0;
        repeat (2) tick();

        // Basic run, cycle table
        for (int i = 0; i < 4; i++) fq.push_back(32'h100 + i);
        upd_fifo();
        tbl[0] = '{1,0,1, 0,0,0,32'h000,0,0};
        tbl[1] = '{1,1,1, 1,0,0,32'h000,0,0};
        tbl[2] = '{0,1,1, 2,1,0,32'h000,0,0};
        tbl[3] = '{0,1,1, 2,1,1,32'h100,0,0};
        tbl[4] = '{0,1,1, 2,1,1,32'h101,0,1};
        tbl[5] = '{0,1,1, 2,1,1,32'h102,0,2};
        tbl[6] = '{0,1,1, 2,0,1,32'h103,0,3};
        tbl[7] = '{0,1,1, 3,0,0,32'h103,0,4};
        tbl[8] = '{0,1,1, 4,0,0,32'h103,1,4};
        tbl[9] = '{0,1,1, 0,0,0,32'h103,0,4};
        for (int i = 0; i < 10; i++) begin
            run_program = tbl[i].run; end_program = tbl[i].endp;
            vec_addr_ready = tbl[i].rdy;
            #1;
            chk("basic_state", {29'd0, seq_state}, {29'd0, tbl[i].st});
            chk("basic_rd",    {31'd0, addr_fifo_rd}, {31'd0, tbl[i].rd});
            chk("basic_valid", {31'd0, vec_addr_valid}, {31'd0, tbl[i].vld});
            if (tbl[i].vld) chk("basic_addr", vec_addr, tbl[i].addr);
            chk("basic_done",  {31'd0, seq_done}, {31'd0, tbl[i].done});
            chk("basic_cnt",   {16'd0, issued_cnt}, {16'd0, tbl[i].cnt});
            tick();
        end
        chk("basic_no_starve", {31'd0, addr_starved}, 0);

        // Consecutive expansion with address wrap
        flush();
        fq.push_back(32'h10); fq.push_back(32'hFFFF_FFFF); upd_fifo();
        addr_fifo_threshold = 2; end_program = 1; vec_addr_ready = 1;
        send_consec_addr = 1; consec_count = 8'd2;
        start_prog();
        run_to_idle(40);
`ifdef DRIVER_SEQ_CONSEC_EN
        exp_q = '{32'h10, 32'h11, 32'h12, 32'hFFFF_FFFF, 32'h0, 32'h1};
`else
        exp_q = '{32'h10, 32'hFFFF_FFFF};
`endif
        chk_acc("consec");
        chk("consec_cnt", {16'd0, issued_cnt}, exp_q.size());
        send_consec_addr = 0; consec_count = 0;

        // Backpressure with ready toggling
        flush();
        for (int i = 0; i < 6; i++) fq.push_back(32'h200 + i);
        upd_fifo();
        addr_fifo_threshold = 1; end_program = 1; unstable = 0;
        start_prog();
        sz = 0;
        for (int c = 0; c < 80; c++) begin
            if (seq_state == 3'd0) break;
            vec_addr_ready = c[0];
            words_in_vctr_fifo = (c >= 4 && c < 9) ? vector_fifo_threshold : 16'd0;
            if (c == 4) sz = fq.size();
            #1;
            if (c >= 4 && c < 9) chk("bp_no_pop", {31'd0, addr_fifo_rd}, 0);
            if (c == 9) chk("bp_fifo_held", fq.size(), sz);
            tick();
        end
        words_in_vctr_fifo = 0; vec_addr_ready = 1;
        run_to_idle(20);
        for (int i = 0; i < 6; i++) exp_q.push_back(32'h200 + i);
        chk_acc("bp");
        chk("bp_stable", unstable, 0);

        // Starvation, then a late end of program
        flush();
        fq.push_back(32'h300); fq.push_back(32'h301); upd_fifo();
        addr_fifo_threshold = 2; end_program = 0;
        d0 = done_cnt;
        start_prog();
        repeat (8) tick();
        chk("starve_flag",  {31'd0, addr_starved}, 1);
        chk("starve_state", {29'd0, seq_state}, 2);
        start_prog();
        tick();
        chk("busy_run_ignored", {29'd0, seq_state}, 2);
        chk("busy_run_cnt",     {16'd0, issued_cnt}, 2);
        fq.push_back(32'h302); fq.push_back(32'h303); upd_fifo();
        end_program = 1;
        run_to_idle(30);
        exp_q = '{32'h300, 32'h301, 32'h302, 32'h303};
        chk_acc("starve");
        chk("starve_done", done_cnt - d0, 1);
        chk("starve_cnt",  {16'd0, issued_cnt}, 4);
        chk("starve_sticky", {31'd0, addr_starved}, 1);

        // Abort with an address pending and a burst in progress
        flush();
        fq.push_back(32'h400); fq.push_back(32'h500); upd_fifo();
        addr_fifo_threshold = 1; end_program = 0; vec_addr_ready = 0;
        send_consec_addr = 1; consec_count = 8'd2;
        start_prog();
        repeat (3) tick();
        chk("abort_pre_valid", {31'd0, vec_addr_valid}, 1);
        abort_program = 1;
        #1 chk("abort_rd", {31'd0, addr_fifo_rd}, 0);
        tick();
        chk("abort_state",  {29'd0, seq_state}, 0);
        chk("abort_valid",  {31'd0, vec_addr_valid}, 0);
        chk("abort_pulse",  {31'd0, seq_aborted}, 1);
        abort_program = 0;
        tick();
        chk("abort_pulse_end", {31'd0, seq_aborted}, 0);
        repeat (3) tick();
        chk("abort_no_pops", fq.size(), 1);
        send_consec_addr = 0; consec_count = 0; vec_addr_ready = 1;

        // Abort in the first RUN cycle, where a pop would otherwise occur
        start_prog();
        tick();
        abort_program = 1;
        #1 chk("abort_first_rd", {31'd0, addr_fifo_rd}, 0);
        tick();
        abort_program = 0;
        chk("abort_first_fifo", fq.size(), 1);
        chk("abort_first_state", {29'd0, seq_state}, 0);

        // Asynchronous reset in the middle of RUN
        flush();
        for (int i = 0; i < 6; i++) fq.push_back(32'h600 + i);
        upd_fifo();
        end_program = 1; vec_addr_ready = 0;
        start_prog();
        repeat (2) tick();
        chk("mid_pre_valid", {31'd0, vec_addr_valid}, 1);
        #3 reset = 1'b1;
        #1;
        chk("mid_rst_state", {29'd0, seq_state}, 0);
        chk("mid_rst_outs",  {26'd0, vec_addr_valid, addr_fifo_rd, seq_busy,
                              seq_done, seq_aborted, addr_starved}, 0);
        chk("mid_rst_addr",  vec_addr, 0);
        chk("mid_rst_cnt",   {16'd0, issued_cnt}, 0);
        @(posedge clk); #1 reset = 1'b0;
        flush();
        tick();

        chk("never_pop_empty", bad_pop, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
